// File: rtl/prod_pkg.sv
// Shared types and helpers for the product accumulator and its neighbours on
// the multiplier datapath.
package prod_pkg;

  localparam int PW_DEF = 32;
  localparam int AW_DEF = 40;

  // Widest operand the zero-extension helper can handle.
  localparam int ZW = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_t;

  // Keeps the low pw bits of p and forces every bit above them to zero.
  function automatic logic [ZW-1:0] zext_prod(input logic [ZW-1:0] p, input int pw);
    logic [ZW-1:0] r;
    r = '0;
    for (int i = 0; i < ZW; i++) begin
      if (i < pw) r[i] = p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/prod_accum_edge_det.sv
// Rising-edge detector: registers a level input and flags a 0->1 transition.
// Also usable on the multiplier's start strobe.
module edge_det (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) sig_q <= 1'b0;
    else           sig_q <= sig_i;
  end

  // A level already high when reset releases is seen as a rising edge.
  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/prod_accum.sv
// Sums NTERMS consecutive multiplier products and pulses sum_valid_o per group.
// Define PROD_ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
//
// state | meaning
// IDLE  | no partial group held, acc and term count are zero
// ACCUM | partial group held, waiting for further products
// DONE  | group just completed: sum_o updated, sum_valid_o high for one cycle
module prod_accum
  import prod_pkg::*;
#(
  parameter int PW     = PW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NTERMS = 4,
  parameter int CW     = 3
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          clr_i,
  input  logic [PW-1:0] prodt_i,
  input  logic          valid_i,
  output logic [AW-1:0] sum_o,
  output logic          sum_valid_o,
  output logic [CW-1:0] term_cnt_o,
  output logic          busy_o,
  output logic          ovf_o
);

  accum_state_t  state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          rise;
  logic          accept;
  logic [AW:0]   prod_ext;
  logic [AW:0]   add_full;
  logic [AW-1:0] add_res;
  logic          carry;
  logic          ovf_base;
  logic          last_term;

  edge_det u_edge_det (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .sig_i    (valid_i),
    .rise_o   (rise)
  );

  assign accept   = rise & ~clr_i;
  assign prod_ext = (AW+1)'(zext_prod(ZW'(prodt_i), PW));

  // acc_q and cnt_q are already zero in IDLE and DONE, so one adder serves
  // both the first term of a group and every later one.
  always_comb begin
    ovf_base  = (state_q == DONE) ? 1'b0 : ovf_q;
    add_full  = {1'b0, acc_q} + prod_ext;
    carry     = add_full[AW];
`ifdef PROD_ACCUM_SATURATE_EN
    add_res   = (carry | ovf_base) ? {AW{1'b1}} : add_full[AW-1:0];
`else
    add_res   = add_full[AW-1:0];
`endif
    last_term = (cnt_q == CW'(NTERMS - 1));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
      end
      DONE: begin
        state_d = IDLE;
        ovf_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    if (accept) begin
      ovf_d = ovf_base | carry;
      if (last_term) begin
        state_d = DONE;
        sum_d   = add_res;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = add_res;
        cnt_d   = cnt_q + 1'b1;
      end
    end

    // Clear abandons the partial group but leaves the last reported sum alone.
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_o       = sum_q;
  assign sum_valid_o = (state_q == DONE);
  assign term_cnt_o  = cnt_q;
  assign busy_o      = (cnt_q != '0);
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: a default instance (AW=40, NTERMS=4) and a
// narrow instance (AW=32, NTERMS=2) that exercises overflow.
module tb_prod_accum;

`ifdef PROD_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [63:0] sum;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [31:0] prodt0;
  logic        valid0, clr0;
  logic [39:0] sum0;
  logic        sv0, busy0, ovf0;
  logic [2:0]  tc0;

  logic [31:0] prodt1;
  logic        valid1, clr1;
  logic [31:0] sum1;
  logic        sv1, busy1, ovf1;
  logic [1:0]  tc1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  longint unsigned tot[2];
  int              cnt[2];

  prod_accum #(.PW(32), .AW(40), .NTERMS(4), .CW(3)) u_dut (
    .clock_i(clk), .reset_ni(rst_n), .clr_i(clr0), .prodt_i(prodt0), .valid_i(valid0),
    .sum_o(sum0), .sum_valid_o(sv0), .term_cnt_o(tc0), .busy_o(busy0), .ovf_o(ovf0)
  );

  prod_accum #(.PW(32), .AW(32), .NTERMS(2), .CW(2)) u_narrow (
    .clock_i(clk), .reset_ni(rst_n), .clr_i(clr1), .prodt_i(prodt1), .valid_i(valid1),
    .sum_o(sum1), .sum_valid_o(sv1), .term_cnt_o(tc1), .busy_o(busy1), .ovf_o(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a group total is the plain sum of its accepted products; the
  // reported value is that total reduced to AW bits by wrap or clamp.
  function automatic void model_term(input int inst, input logic [31:0] p);
    exp_t e;
    int nt;
    int aw;
    longint unsigned lim;
    nt = (inst == 0) ? 4 : 2;
    aw = (inst == 0) ? 40 : 32;
    tot[inst] += longint'(p);
    cnt[inst]++;
    if (cnt[inst] == nt) begin
      lim   = 64'd1 << aw;
      e.ovf = (tot[inst] >= lim);
      if (!e.ovf)   e.sum = tot[inst];
      else if (SAT) e.sum = lim - 1;
      else          e.sum = tot[inst] % lim;
      if (inst == 0) exp_q0.push_back(e);
      else           exp_q1.push_back(e);
      tot[inst] = 0;
      cnt[inst] = 0;
    end
  endfunction

  function automatic void model_clear(input int inst);
    tot[inst] = 0;
    cnt[inst] = 0;
  endfunction

  // Presents one product as a rising edge held for 'hold' cycles, then drops valid.
  task automatic pulse(input int inst, input logic [31:0] p, input int hold);
    if (inst == 0) begin prodt0 = p; valid0 = 1'b1; end
    else           begin prodt1 = p; valid1 = 1'b1; end
    model_term(inst, p);
    repeat (hold) @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && sv0) begin
      if (exp_q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sum0_unexpected: got sum_valid with sum 0x%0h, expected no pulse", sum0);
      end else begin
        e = exp_q0.pop_front();
        check("sum0", 64'(sum0), e.sum);
        check("ovf0", 64'(ovf0), 64'(e.ovf));
      end
    end
    if (rst_n && sv1) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sum1_unexpected: got sum_valid with sum 0x%0h, expected no pulse", sum1);
      end else begin
        e = exp_q1.pop_front();
        check("sum1", 64'(sum1), e.sum);
        check("ovf1", 64'(ovf1), 64'(e.ovf));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"},  64'(sum0),  64'd0);
    check({tag, "_sv"},   64'(sv0),   64'd0);
    check({tag, "_tc"},   64'(tc0),   64'd0);
    check({tag, "_busy"}, 64'(busy0), 64'd0);
    check({tag, "_ovf"},  64'(ovf0),  64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    prodt0 = '0; valid0 = 1'b0; clr0 = 1'b0;
    prodt1 = '0; valid1 = 1'b0; clr1 = 1'b0;
    model_clear(0);
    model_clear(1);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single group of identical products.
    repeat (4) pulse(0, 32'h7E069524, 1);
    check("grp1_tc", 64'(tc0), 64'd0);
    check("grp1_sv_one_cycle", 64'(sv0), 64'd0);
    check("grp1_sum_hold", 64'(sum0), 64'h01F81A5490);

    // Held valid is counted once, then the max-value group completes.
    prodt0 = 32'hFFFE0001;
    valid0 = 1'b1;
    model_term(0, 32'hFFFE0001);
    repeat (13) @(negedge clk);
    check("held_tc", 64'(tc0), 64'd1);
    check("held_busy", 64'(busy0), 64'd1);
    valid0 = 1'b0;
    @(negedge clk);
    repeat (3) pulse(0, 32'hFFFE0001, 2);
    check("max_sum", 64'(sum0), 64'h03FFF80004);

    // clr coincident with a rising edge discards the product; held valid ignored.
    pulse(0, 32'h10, 1);
    pulse(0, 32'h10, 1);
    check("pre_clr_tc", 64'(tc0), 64'd2);
    prodt0 = 32'h20;
    valid0 = 1'b1;
    clr0   = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    model_clear(0);
    @(negedge clk);
    check("clr_tc", 64'(tc0), 64'd0);
    check("clr_busy", 64'(busy0), 64'd0);
    check("clr_sum_kept", 64'(sum0), 64'h03FFF80004);
    valid0 = 1'b0;
    @(negedge clk);
    repeat (4) pulse(0, 32'h1, 1);
    check("after_clr_sum", 64'(sum0), 64'd4);

    // Asynchronous reset between clock edges in the middle of a group.
    pulse(0, 32'h1234, 1);
    pulse(0, 32'h5678, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) pulse(0, $urandom, 1);

    // Valid already high when reset releases counts as the first term.
    rst_n = 1'b0;
    model_clear(0);
    model_clear(1);
    prodt0 = 32'd5;
    valid0 = 1'b1;
    model_term(0, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    check("rel_high_tc", 64'(tc0), 64'd1);
    @(negedge clk);
    pulse(0, 32'd6, 1);
    pulse(0, 32'd7, 3);
    pulse(0, 32'd8, 1);
    check("rel_high_sum", 64'(sum0), 64'd26);

    // Random products, hold lengths, gaps and occasional clears.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        model_clear(0);
      end else if (r == 1) begin
        prodt0 = $urandom;
        valid0 = 1'b1;
        clr0   = 1'b1;
        @(negedge clk);
        clr0   = 1'b0;
        valid0 = 1'b0;
        model_clear(0);
        @(negedge clk);
      end else begin
        pulse(0, $urandom, $urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Narrow instance: overflow, then a clean group showing ovf cleared.
    pulse(1, 32'hFFFE0001, 1);
    pulse(1, 32'hFFFE0001, 1);
    check("ovf_sum", 64'(sum1), SAT ? 64'hFFFFFFFF : 64'hFFFC0002);
    check("ovf_cleared", 64'(ovf1), 64'd0);
    pulse(1, 32'd1, 1);
    pulse(1, 32'd2, 1);
    check("narrow_sum", 64'(sum1), 64'd3);
    for (int i = 0; i < 12; i++) pulse(1, $urandom, $urandom_range(1, 2));

    repeat (4) @(negedge clk);
    check("drain0", 64'(exp_q0.size()), 64'd0);
    check("drain1", 64'(exp_q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
